lif_neuron_tile: RTL and testbench

Parametrised leaky-integrate-and-fire neuron tile for the spiking accelerator datapath. Holds `size_tile` membrane potentials and accumulates one signed weight row per accepted cycle from the memory router. It then applies a configurable shift leak, compares against a threshold and applies a selectable reset mode. It generalises the fixed-function neuron tile with run-time input count, leak, threshold, reset mode, saturating arithmetic and a stall-capable weight handshake.

---
 rtl/lif_neuron_tile_if.sv | 44 ++++
 rtl/lif_neuron_tile.sv | 217 +++++++++++++++++++++
 tb/tb_lif_neuron_tile.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_neuron_tile_if.sv
// -----------------------------------------------------------------------------
// lif_neuron_tile_if
//
// Weight-row channel between the memory router (master) and a LIF neuron
// tile (slave).
//
// Handshake:
//    - weightReq is driven by the tile. It is high while the tile is
//      accumulating and can take a row.
//    - memReady is driven by the router. It is high when weightData carries
//      a valid row.
//    - A row is transferred on every rising clock edge where weightReq and
//      memReady are both high.
//    - The router may raise memReady at any time. The tile ignores it while
//      weightReq is low.
//    - There is no buffering. The tile consumes the row on the same edge it
//      is offered.
//
// Signals:
//    memReady    router -> tile   weightData valid this cycle
//    weightData  router -> tile   one signed weight per neuron; neuron i
//                                 occupies [i*size_data +: size_data]
//    weightReq   tile -> router   tile wants a weight row
// -----------------------------------------------------------------------------
interface lif_neuron_tile_if #(
   parameter int size_tile = 4,
   parameter int size_data = 8
);
   logic                           memReady;
   logic [size_tile*size_data-1:0] weightData;
   logic                           weightReq;

   modport master (
      output memReady,
      output weightData,
      input  weightReq
   );

   modport slave (
      input  memReady,
      input  weightData,
      output weightReq
   );
endinterface

// File: rtl/lif_neuron_tile.sv
// -----------------------------------------------------------------------------
// lif_neuron_tile
//
// Leaky-integrate-and-fire neuron tile. It holds size_tile signed membrane
// potentials. Each run has four steps:
//    1. enable loads the initial potentials and latches the run
//       configuration.
//    2. numInputs weight rows are accumulated with saturation, one row per
//       accepted cycle.
//    3. A single FIRE cycle applies the shift leak, compares each neuron
//       against the threshold, and applies the selected reset mode.
//    4. finished pulses for one cycle.
//
// Ports:
//    clk         single clock, rising edge
//    reset       synchronous, active-low reset
//    enable      start pulse; sampled only in IDLE
//    numInputs   weight rows to accumulate; sampled with enable
//    vmemData    initial potentials, neuron i at [i*size_vmem +: size_vmem]
//    threshold   signed firing threshold; latched with enable
//    leakShift   leak shift amount; 0 disables the leak; latched with enable
//    resetMode   0 = reset to zero, 1 = subtract threshold; latched with enable
//    mem         weight-row channel (memReady, weightData in; weightReq out)
//    finished    one-cycle done pulse
//    spikeOut    per-neuron spike result of the last FIRE
//    vmemOut     current membrane potentials
//    stateOut    FSM state: 00 IDLE, 01 ACCUM, 10 FIRE, 11 DONE
// -----------------------------------------------------------------------------
module lif_neuron_tile #(
   parameter int size_data     = 8,
   parameter int size_vmem     = 16,
   parameter int size_tile     = 4,
   parameter int size_counters = 5
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [size_counters-1:0]       numInputs,
   input  logic [size_tile*size_vmem-1:0] vmemData,
   input  logic signed [size_vmem-1:0]    threshold,
   input  logic [3:0]                     leakShift,
   input  logic                           resetMode,
   lif_neuron_tile_if.slave               mem,
   output logic                           finished,
   output logic [size_tile-1:0]           spikeOut,
   output logic [size_tile*size_vmem-1:0] vmemOut,
   output logic [1:0]                     stateOut
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_ACCUM = 2'b01;
   localparam logic [1:0] ST_FIRE  = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   // Saturation limits of one membrane potential.
   localparam logic signed [size_vmem-1:0] VMEM_MAX = {1'b0, {(size_vmem-1){1'b1}}};
   localparam logic signed [size_vmem-1:0] VMEM_MIN = {1'b1, {(size_vmem-1){1'b0}}};

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [1:0]                  r_state;
   logic [size_counters-1:0]    r_count;
   logic [size_counters-1:0]    r_num_inputs;
   logic signed [size_vmem-1:0] r_thresh;
   logic [3:0]                  r_leak;
   logic                        r_mode;
   logic signed [size_vmem-1:0] r_vmem [size_tile];
   logic [size_tile-1:0]        r_spike;
   logic                        r_finished;

   // ---------------------------------------------------------------------------
   // Per-neuron datapath
   // ---------------------------------------------------------------------------
   logic signed [size_data-1:0] w_weight  [size_tile];
   logic signed [size_vmem:0]   w_sum     [size_tile];
   logic signed [size_vmem-1:0] w_acc     [size_tile];
   logic signed [size_vmem-1:0] w_shifted [size_tile];
   logic signed [size_vmem-1:0] w_leaked  [size_tile];
   logic signed [size_vmem:0]   w_diff    [size_tile];
   logic signed [size_vmem-1:0] w_fire    [size_tile];
   logic [size_tile-1:0]        w_spike;
   logic                        w_last_row;

   // Clamp a one-bit-wider intermediate back to the vmem range. Overflow
   // shows up as disagreement between the two top bits, and the top bit
   // tells which way it went.
   function automatic logic signed [size_vmem-1:0] sat_vmem(input logic signed [size_vmem:0] x);
      logic signed [size_vmem-1:0] res;
      if (x[size_vmem] != x[size_vmem-1]) begin
         res = x[size_vmem] ? VMEM_MIN : VMEM_MAX;
      end else begin
         res = x[size_vmem-1:0];
      end
      return res;
   endfunction

   always_comb begin
      w_spike = '0;
      for (int i = 0; i < size_tile; i++) begin
         w_weight[i]  = '0;
         w_sum[i]     = '0;
         w_acc[i]     = '0;
         w_shifted[i] = '0;
         w_leaked[i]  = '0;
         w_diff[i]    = '0;
         w_fire[i]    = '0;
      end

      for (int i = 0; i < size_tile; i++) begin
         // Accumulate: sign-extend both operands to size_vmem+1 bits, then clamp.
         w_weight[i] = mem.weightData[i*size_data +: size_data];
         w_sum[i]    = {r_vmem[i][size_vmem-1], r_vmem[i]}
                     + {{(size_vmem+1-size_data){w_weight[i][size_data-1]}}, w_weight[i]};
         w_acc[i]    = sat_vmem(w_sum[i]);

         // Leak: v - (v >>> s). The result always lies between 0 and v, so
         // it cannot overflow. A shift of 0 must bypass the leak, because
         // v - (v >>> 0) would give zero.
         w_shifted[i] = r_vmem[i] >>> r_leak;
         w_leaked[i]  = (r_leak == 4'd0) ? r_vmem[i] : (r_vmem[i] - w_shifted[i]);

         // Fire: signed compare. Subtracting a negative threshold can
         // overflow, so the subtraction is done one bit wider and clamped.
         w_spike[i] = (w_leaked[i] >= r_thresh);
         w_diff[i]  = {w_leaked[i][size_vmem-1], w_leaked[i]}
                    - {r_thresh[size_vmem-1], r_thresh};
         if (w_spike[i]) begin
            w_fire[i] = r_mode ? sat_vmem(w_diff[i]) : '0;
         end else begin
            w_fire[i] = w_leaked[i];
         end
      end
   end

   // The row now being accepted is the last one for this run.
   assign w_last_row = (r_count == (r_num_inputs - 1'b1));

   // ---------------------------------------------------------------------------
   // FSM and state registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_num_inputs <= '0;
         r_thresh     <= '0;
         r_leak       <= '0;
         r_mode       <= 1'b0;
         r_spike      <= '0;
         r_finished   <= 1'b0;
         for (int i = 0; i < size_tile; i++) begin
            r_vmem[i] <= '0;
         end
      end else begin
         r_finished <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  for (int i = 0; i < size_tile; i++) begin
                     r_vmem[i] <= vmemData[i*size_vmem +: size_vmem];
                  end
                  r_num_inputs <= numInputs;
                  r_thresh     <= threshold;
                  r_leak       <= leakShift;
                  r_mode       <= resetMode;
                  r_count      <= '0;
                  r_spike      <= '0;
                  r_state      <= (numInputs == '0) ? ST_FIRE : ST_ACCUM;
               end
            end

            ST_ACCUM: begin
               // Without memReady this is a stall cycle: vmem and counter hold.
               if (mem.memReady) begin
                  for (int i = 0; i < size_tile; i++) begin
                     r_vmem[i] <= w_acc[i];
                  end
                  r_count <= r_count + 1'b1;
                  if (w_last_row) begin
                     r_state <= ST_FIRE;
                  end
               end
            end

            ST_FIRE: begin
               for (int i = 0; i < size_tile; i++) begin
                  r_vmem[i] <= w_fire[i];
               end
               r_spike    <= w_spike;
               r_finished <= 1'b1;
               r_state    <= ST_DONE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      vmemOut = '0;
      for (int i = 0; i < size_tile; i++) begin
         vmemOut[i*size_vmem +: size_vmem] = r_vmem[i];
      end
   end

   assign mem.weightReq = (r_state == ST_ACCUM);
   assign finished      = r_finished;
   assign spikeOut      = r_spike;
   assign stateOut      = r_state;

endmodule

// File: tb/tb_lif_neuron_tile.sv
module tb_lif_neuron_tile;
   localparam int SD = 8;
   localparam int SV = 16;
   localparam int ST = 4;
   localparam int SC = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic [SC-1:0]     numInputs = '0;
   logic [ST*SV-1:0]  vmemData = '0;
   logic [SV-1:0]     threshold = '0;
   logic [3:0]        leakShift = '0;
   logic              resetMode = 1'b0;
   logic              finished;
   logic [ST-1:0]     spikeOut;
   logic [ST*SV-1:0]  vmemOut;
   logic [1:0]        stateOut;

   lif_neuron_tile_if #(.size_tile(ST), .size_data(SD)) mem_if ();

   lif_neuron_tile #(
      .size_data(SD), .size_vmem(SV), .size_tile(ST), .size_counters(SC)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .numInputs(numInputs),
      .vmemData(vmemData), .threshold(threshold), .leakShift(leakShift),
      .resetMode(resetMode), .mem(mem_if), .finished(finished),
      .spikeOut(spikeOut), .vmemOut(vmemOut), .stateOut(stateOut)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   int v_init [ST];
   int w_rows [32][ST];
   int mv     [ST];
   logic [ST-1:0] m_spike;

   function automatic int clamp(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic logic [63:0] pack_v(input int a [ST]);
      logic [63:0] r;
      int t;
      r = '0;
      for (int i = 0; i < ST; i++) begin
         t = a[i];
         r[i*SV +: SV] = t[SV-1:0];
      end
      return r;
   endfunction

   function automatic logic [ST*SD-1:0] pack_w(input int row);
      logic [ST*SD-1:0] r;
      int t;
      r = '0;
      for (int i = 0; i < ST; i++) begin
         t = w_rows[row][i];
         r[i*SD +: SD] = t[SD-1:0];
      end
      return r;
   endfunction

   // Floor division by 2^s written out as arithmetic.
   function automatic int floor_div_pow2(input int v, input int s);
      int d, q;
      d = 1 << s;
      q = v / d;
      if ((v < 0) && (q * d != v)) q = q - 1;
      return q;
   endfunction

   function automatic void model_fire(input int thr, input int ls, input bit rm);
      int lv;
      for (int i = 0; i < ST; i++) begin
         lv = (ls == 0) ? mv[i] : mv[i] - floor_div_pow2(mv[i], ls);
         m_spike[i] = (lv >= thr);
         if (lv >= thr) mv[i] = rm ? clamp(lv - thr) : 0;
         else mv[i] = lv;
      end
   endfunction

   function automatic int rnd_s(input int lo, input int hi);
      return lo + int'($urandom_range(0, hi - lo));
   endfunction

   // ---------------- driver ----------------
   // Called at a falling edge with the DUT in IDLE; returns at the falling
   // edge of the IDLE cycle right after DONE.
   // stall_mode: 0 = always ready, 1 = ready on odd cycles, 2 = random.
   task automatic run_case(input int n, input int stall_mode, input int thr,
                           input int ls, input bit rm);
      int rows, c;
      bit ready;
      logic [SV-1:0] thr_bits;
      thr_bits = thr[SV-1:0];
      enable = 1'b1;
      numInputs = n[SC-1:0];
      vmemData = pack_v(v_init);
      threshold = thr_bits;
      leakShift = ls[3:0];
      resetMode = rm;
      mem_if.memReady = 1'($urandom_range(0, 1));
      mem_if.weightData = $urandom;
      for (int i = 0; i < ST; i++) mv[i] = v_init[i];
      @(posedge clk); @(negedge clk);
      c = 1;
      rows = 0;
      while (rows < n) begin
         chk("accum_state", stateOut, 2'b01);
         chk("accum_weightReq", mem_if.weightReq, 1'b1);
         chk("accum_finished", finished, 1'b0);
         chk("accum_spike_cleared", spikeOut, '0);
         chk("accum_vmem", vmemOut, pack_v(mv));
         case (stall_mode)
            0: ready = 1'b1;
            1: ready = (c % 2) == 1;
            default: ready = ($urandom_range(0, 2) != 0) || (c > 150);
         endcase
         // Spurious enable and garbage config must be ignored outside IDLE.
         enable = 1'($urandom_range(0, 1));
         vmemData = {$urandom, $urandom};
         numInputs = 5'($urandom_range(0, 31));
         mem_if.memReady = ready;
         mem_if.weightData = ready ? pack_w(rows) : ST*SD'($urandom);
         if (ready) begin
            for (int i = 0; i < ST; i++) mv[i] = clamp(mv[i] + w_rows[rows][i]);
         end
         @(posedge clk); @(negedge clk);
         if (ready) rows++;
         c++;
      end
      enable = 1'b0;
      chk("fire_state", stateOut, 2'b10);
      chk("fire_weightReq", mem_if.weightReq, 1'b0);
      chk("fire_finished", finished, 1'b0);
      chk("fire_vmem_pre", vmemOut, pack_v(mv));
      // memReady in FIRE must not accumulate.
      mem_if.memReady = 1'b1;
      mem_if.weightData = $urandom;
      model_fire(thr, ls, rm);
      @(posedge clk); @(negedge clk);
      c++;
      mem_if.memReady = 1'b0;
      chk("done_finished", finished, 1'b1);
      chk("done_state", stateOut, 2'b11);
      chk("done_spike", spikeOut, m_spike);
      chk("done_vmem", vmemOut, pack_v(mv));
      @(posedge clk); @(negedge clk);
      chk("idle_finished", finished, 1'b0);
      chk("idle_state", stateOut, 2'b00);
      chk("idle_spike_hold", spikeOut, m_spike);
      chk("idle_vmem_hold", vmemOut, pack_v(mv));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      mem_if.memReady = 1'b0;
      mem_if.weightData = '0;

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_state", stateOut, 2'b00);
      chk("rst_vmem", vmemOut, '0);
      chk("rst_spike", spikeOut, '0);
      chk("rst_finished", finished, 1'b0);
      chk("rst_weightReq", mem_if.weightReq, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // Reset in the middle of ACCUM, after 2 of 5 rows.
      for (int i = 0; i < ST; i++) v_init[i] = rnd_s(-1000, 1000);
      for (int r = 0; r < 5; r++) for (int i = 0; i < ST; i++) w_rows[r][i] = rnd_s(-128, 127);
      enable = 1'b1;
      numInputs = 5'd5;
      vmemData = pack_v(v_init);
      threshold = 16'd10;
      @(posedge clk); @(negedge clk);
      enable = 1'b0;
      for (int r = 0; r < 2; r++) begin
         mem_if.memReady = 1'b1;
         mem_if.weightData = pack_w(r);
         @(posedge clk); @(negedge clk);
      end
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("abort_state", stateOut, 2'b00);
      chk("abort_vmem", vmemOut, '0);
      chk("abort_spike", spikeOut, '0);
      chk("abort_finished", finished, 1'b0);
      chk("abort_weightReq", mem_if.weightReq, 1'b0);
      reset = 1'b1;
      mem_if.memReady = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); @(negedge clk);
         chk("abort_no_finished", finished, 1'b0);
         chk("abort_stays_idle", stateOut, 2'b00);
      end

      // Three rows of {4,-2,6,1}, threshold 10, reset to zero.
      for (int i = 0; i < ST; i++) v_init[i] = 0;
      for (int r = 0; r < 3; r++) begin
         w_rows[r][0] = 4; w_rows[r][1] = -2; w_rows[r][2] = 6; w_rows[r][3] = 1;
      end
      run_case(3, 0, 10, 0, 1'b0);
      chk("rm0_spike_const", spikeOut, 4'b0101);
      chk("rm0_vmem_const", vmemOut, 64'h0003_0000_FFFA_0000);

      // Same stimulus, subtract-threshold reset, back to back.
      run_case(3, 0, 10, 0, 1'b1);
      chk("rm1_spike_const", spikeOut, 4'b0101);
      chk("rm1_vmem_const", vmemOut, 64'h0003_0008_FFFA_0002);

      // Leak only: N=0, v=64, shift 2 -> 48, no spike.
      for (int i = 0; i < ST; i++) v_init[i] = 64;
      run_case(0, 0, 100, 2, 1'b0);
      chk("leak_vmem_const", vmemOut, 64'h0030_0030_0030_0030);
      chk("leak_spike_const", spikeOut, 4'b0000);

      // Saturation in both directions over 2 rows.
      v_init[0] = 32760; v_init[1] = -32760; v_init[2] = 0; v_init[3] = -5;
      for (int r = 0; r < 2; r++) begin
         w_rows[r][0] = 127; w_rows[r][1] = -128; w_rows[r][2] = 0; w_rows[r][3] = 1;
      end
      run_case(2, 0, 32767, 0, 1'b0);
      chk("sat_neg_const", vmemOut[31:16], 16'h8000);
      chk("sat_pos_spike_const", spikeOut[0], 1'b1);

      // Alternating stalls, N=4, spurious enable pulses during ACCUM.
      for (int i = 0; i < ST; i++) v_init[i] = rnd_s(-200, 200);
      for (int r = 0; r < 4; r++) for (int i = 0; i < ST; i++) w_rows[r][i] = rnd_s(-128, 127);
      run_case(4, 1, 50, 1, 1'b1);

      // Randomized runs.
      for (int k = 0; k < 30; k++) begin
         int n, thr, ls;
         bit rm;
         n = (k % 10 == 9) ? 31 : int'($urandom_range(0, 12));
         for (int i = 0; i < ST; i++)
            v_init[i] = (k % 3 == 0) ? rnd_s(-32768, 32767) : rnd_s(-600, 600);
         for (int r = 0; r < n; r++) for (int i = 0; i < ST; i++) w_rows[r][i] = rnd_s(-128, 127);
         thr = (k % 4 == 0) ? rnd_s(-32768, 32767) : rnd_s(-300, 300);
         ls = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
         rm = 1'($urandom_range(0, 1));
         run_case(n, 2, thr, ls, rm);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
